prvp_dc_token_ring_fifo_din: RTL and testbench



---
 rtl/prvp_dc_token_ring_fifo_din_pkg.sv | 6 +
 rtl/prvp_dc_token_ring_fifo_din_if.sv | 21 ++
 rtl/prvp_dc_synchronizer.sv | 23 ++
 rtl/prvp_dc_token_ring.sv | 19 +
 rtl/prvp_dc_token_ring_fifo_din.sv | 79 +++++++
 tb/tb_prvp_dc_token_ring_fifo_din.sv | 206 ++++++++++++++++++++
 6 files changed

// File: rtl/prvp_dc_token_ring_fifo_din_pkg.sv
// Constants shared by both halves of the token-ring dual-clock FIFO.
// Reset slots must match prvp_dc_token_ring_fifo_dout.
package prvp_dc_token_ring_fifo_din_pkg;
  localparam logic [31:0] FIFO_RING_RESET = 32'hc;
  localparam logic [31:0] RP_SYNC_RESET = 32'h8;
endpackage

// File: rtl/prvp_dc_token_ring_fifo_din_if.sv
// Producer-side valid/ready word handshake.
// master drives words, slave accepts them.
interface prvp_dc_token_ring_fifo_din_if #(
  parameter int DATA_WIDTH = 10
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/prvp_dc_synchronizer.sv
// Two-flop synchronizer for a bus of one-hot pointer bits.
// Bits are sampled independently.
module prvp_dc_synchronizer #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/prvp_dc_token_ring.sv
// Rotating token ring; shifts left by one slot when enabled.
// Holds its state otherwise.
module prvp_dc_token_ring #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  output logic [WIDTH-1:0] state
);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= RESET_VALUE;
    end else if (enable) begin
      state <= {state[WIDTH-2:0], state[WIDTH-1]};
    end
  end
endmodule

// File: rtl/prvp_dc_token_ring_fifo_din.sv
// Write half of the token-ring dual-clock FIFO.
// Stores words and exposes the read-selected entry asynchronously.
module prvp_dc_token_ring_fifo_din
  import prvp_dc_token_ring_fifo_din_pkg::*;
#(
  parameter int DATA_WIDTH   = 10,
  parameter int BUFFER_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  prvp_dc_token_ring_fifo_din_if.slave wr,
  output logic [BUFFER_DEPTH-1:0] write_token,
  input  logic [BUFFER_DEPTH-1:0] read_pointer,
  output logic [DATA_WIDTH-1:0]   data_async
);
  localparam logic [BUFFER_DEPTH-1:0] RING_RST =
    BUFFER_DEPTH'(FIFO_RING_RESET);
  localparam logic [BUFFER_DEPTH-1:0] SYNC_RST =
    BUFFER_DEPTH'(RP_SYNC_RESET);

  logic [BUFFER_DEPTH-1:0] ring;
  logic [BUFFER_DEPTH-1:0] write_pointer;
  logic [BUFFER_DEPTH-1:0] rp_sync;
  logic [BUFFER_DEPTH-1:0] guard;
  logic [DATA_WIDTH-1:0]   buffer [BUFFER_DEPTH];
  logic                    accept;

  assign accept = wr.valid & wr.ready;

  prvp_dc_token_ring #(
    .WIDTH       (BUFFER_DEPTH),
    .RESET_VALUE (RING_RST)
  ) u_ring (
    .clk    (clk),
    .rstn   (rstn),
    .enable (accept),
    .state  (ring)
  );

  prvp_dc_synchronizer #(
    .WIDTH       (BUFFER_DEPTH),
    .RESET_VALUE (SYNC_RST)
  ) u_rp_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (read_pointer),
    .q    (rp_sync)
  );

  assign write_token   = ring;
  assign write_pointer = ring & {ring[0], ring[BUFFER_DEPTH-1:1]};

  // Three slots ahead of the write slot: two-slot margin for sync lag.
  assign guard = {write_pointer[BUFFER_DEPTH-4:0],
                  write_pointer[BUFFER_DEPTH-1:BUFFER_DEPTH-3]};
  assign wr.ready = ~|(guard & rp_sync);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < BUFFER_DEPTH; i++) begin
        buffer[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < BUFFER_DEPTH; i++) begin
        if (write_pointer[i]) begin
          buffer[i] <= wr.data;
        end
      end
    end
  end

  always_comb begin
    data_async = '0;
    for (int i = 0; i < BUFFER_DEPTH; i++) begin
      data_async = data_async |
        (buffer[i] & {DATA_WIDTH{read_pointer[i]}});
    end
  end
endmodule

// File: tb/tb_prvp_dc_token_ring_fifo_din.sv
// Bench for the write half of the token-ring dual-clock FIFO.
// Vector table for the fill, hand sequences for sync and reset cases.
module tb_prvp_dc_token_ring_fifo_din;
  localparam int DW = 10;
  localparam int BD = 8;

  typedef struct {
    logic          valid;
    logic [DW-1:0] data;
    logic [BD-1:0] rp;
    logic          exp_ready;
    logic [BD-1:0] exp_token;
    int            exp_slot;
  } vec_t;

  typedef struct {
    int            slot;
    logic [DW-1:0] word;
  } sb_t;

  logic          clk;
  logic          rstn;
  logic [BD-1:0] write_token;
  logic [BD-1:0] read_pointer;
  logic [DW-1:0] data_async;

  int n_vec;
  int n_err;
  sb_t sb [$];
  vec_t fill [8];

  prvp_dc_token_ring_fifo_din_if #(.DATA_WIDTH(DW)) wr_if ();

  prvp_dc_token_ring_fifo_din #(
    .DATA_WIDTH   (DW),
    .BUFFER_DEPTH (BD)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .wr           (wr_if.slave),
    .write_token  (write_token),
    .read_pointer (read_pointer),
    .data_async   (data_async)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, want 'h%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr_if.valid = 1'b0;
    wr_if.data = '0;
    read_pointer = 8'h08;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    #1;
  endtask

  task automatic drain(input string name);
    sb_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      read_pointer = BD'(1) << e.slot;
      #1;
      check(name, 32'(data_async), 32'(e.word));
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (wr_if.ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (wr_if.ready !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: ready timeout, got %b, want 1",
               name, wr_if.ready);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    // Fill from reset with rp fixed at slot 3: six words, then full.
    fill[0] = '{1'b1, 10'h001, 8'h08, 1'b1, 8'h0c, 2};
    fill[1] = '{1'b1, 10'h002, 8'h08, 1'b1, 8'h18, 3};
    fill[2] = '{1'b1, 10'h003, 8'h08, 1'b1, 8'h30, 4};
    fill[3] = '{1'b1, 10'h004, 8'h08, 1'b1, 8'h60, 5};
    fill[4] = '{1'b1, 10'h005, 8'h08, 1'b1, 8'hc0, 6};
    fill[5] = '{1'b1, 10'h006, 8'h08, 1'b1, 8'h81, 7};
    fill[6] = '{1'b1, 10'h007, 8'h08, 1'b0, 8'h03, 0};
    fill[7] = '{1'b1, 10'h007, 8'h08, 1'b0, 8'h03, 0};

    wr_if.valid = 1'b0;
    wr_if.data = '0;
    read_pointer = 8'h04;
    rstn = 1'b0;
    #12;
    check("rst_data_async", 32'(data_async), 0);
    check("rst_ready_low", 32'(wr_if.ready), 1);
    do_reset();
    check("rst_ready", 32'(wr_if.ready), 1);
    check("rst_token", 32'(write_token), 32'h0c);
    check("rst_data", 32'(data_async), 0);

    // Single write
    step();
    wr_if.valid = 1'b1;
    wr_if.data = 10'h155;
    step();
    wr_if.valid = 1'b0;
    check("one_token", 32'(write_token), 32'h18);
    read_pointer = 8'h04;
    #1;
    check("one_data", 32'(data_async), 32'h155);

    // Table-driven fill
    do_reset();
    for (int i = 0; i < 8; i++) begin
      wr_if.valid = fill[i].valid;
      wr_if.data = fill[i].data;
      read_pointer = fill[i].rp;
      #1;
      check($sformatf("fill%0d_ready", i),
            32'(wr_if.ready), 32'(fill[i].exp_ready));
      check($sformatf("fill%0d_token", i),
            32'(write_token), 32'(fill[i].exp_token));
      if (fill[i].valid && fill[i].exp_ready)
        sb.push_back('{fill[i].exp_slot, fill[i].data});
      step();
    end

    // Read pointer advance is seen two edges later
    read_pointer = 8'h10;
    #1;
    check("adv_e0_ready", 32'(wr_if.ready), 0);
    step();
    check("adv_e1_ready", 32'(wr_if.ready), 0);
    step();
    check("adv_e2_ready", 32'(wr_if.ready), 1);
    check("adv_e2_token", 32'(write_token), 32'h03);
    sb.push_back('{0, 10'h007});
    step();
    wr_if.valid = 1'b0;
    check("adv_token", 32'(write_token), 32'h06);
    check("adv_full_again", 32'(wr_if.ready), 0);
    drain("fill_data");

    // Wrap: 16 words, reader follows the writer
    do_reset();
    for (int i = 0; i < 16; i++) begin
      wait_ready("wrap_wait");
      wr_if.valid = 1'b1;
      wr_if.data = DW'(10'h200 + i);
      sb.push_back('{(2 + i) % BD, DW'(10'h200 + i)});
      step();
      wr_if.valid = 1'b0;
      if (i == 7 || i == 15)
        check("wrap_token", 32'(write_token), 32'h0c);
      drain("wrap_data");
      repeat (2) step();
    end

    // Reset after three writes
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wr_if.valid = 1'b1;
      wr_if.data = DW'(10'h3f0 + i);
      step();
    end
    wr_if.valid = 1'b0;
    check("mid_token_pre", 32'(write_token), 32'h60);
    do_reset();
    check("mid_ready", 32'(wr_if.ready), 1);
    check("mid_token", 32'(write_token), 32'h0c);
    for (int s = 0; s < BD; s++) begin
      read_pointer = BD'(1) << s;
      #1;
      check($sformatf("mid_slot%0d", s), 32'(data_async), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
